// File: rtl/rr_arbiter_16.sv
// Sixteen-way round-robin arbiter with a per-grant hold-time limit.
// One grant at a time, one-hot plus binary index, always separated by an idle cycle.
module rr_arbiter_16 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic [15:0] i_req,
    output logic [15:0] o_gnt,
    output logic [3:0]  o_gnt_idx,
    output logic        o_gnt_valid,
    output logic        o_timeout
);

    localparam logic [0:0]  ST_IDLE    = 1'b0;
    localparam logic [0:0]  ST_GRANT   = 1'b1;
    localparam logic [15:0] LP_MAX     = 16'(MAX_HOLD);
    localparam bit          LP_LIMITED = (MAX_HOLD != 0);

    logic [0:0]  r_state;
    logic [3:0]  r_ptr;
    logic [15:0] r_hold_cnt;
    logic [15:0] r_gnt;
    logic [3:0]  r_gnt_idx;
    logic        r_gnt_valid;
    logic        r_timeout;

    logic [15:0] w_req_rot;
    logic [3:0]  w_off;
    logic [3:0]  w_sel;
    logic [15:0] w_onehot;
    logic        w_any;
    logic        w_req_held;
    logic        w_limit;

    // Bit j of the rotated vector is requester (ptr + j) mod 16, so the
    // lowest set bit is the first requester found scanning up from ptr.
    assign w_req_rot = (i_req >> r_ptr) | (i_req << (5'd16 - {1'b0, r_ptr}));

    always_comb begin
        w_off = 4'd0;
        for (int j = 15; j >= 0; j--) begin
            if (w_req_rot[j]) begin
                w_off = 4'(j);
            end
        end
    end

    assign w_sel      = r_ptr + w_off;
    assign w_any      = |i_req;
    assign w_req_held = i_req[r_gnt_idx];
    assign w_limit    = LP_LIMITED && (r_hold_cnt == LP_MAX);

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_onehot
            assign w_onehot[gi] = (w_sel == 4'(gi));
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= 4'd0;
            r_hold_cnt  <= 16'd0;
            r_gnt       <= 16'd0;
            r_gnt_idx   <= 4'd0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_en && w_any) begin
                        r_gnt       <= w_onehot;
                        r_gnt_idx   <= w_sel;
                        r_gnt_valid <= 1'b1;
                        r_hold_cnt  <= 16'd1;
                        r_state     <= ST_GRANT;
                    end
                end
                default: begin
                    if (!w_req_held || w_limit) begin
                        r_gnt       <= 16'd0;
                        r_gnt_idx   <= 4'd0;
                        r_gnt_valid <= 1'b0;
                        r_hold_cnt  <= 16'd0;
                        r_ptr       <= r_gnt_idx + 4'd1;
                        r_state     <= ST_IDLE;
                        // A release in the same cycle as the limit wins: no pulse.
                        r_timeout   <= w_req_held;
                    end else if (r_hold_cnt != 16'hFFFF) begin
                        r_hold_cnt <= r_hold_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

    assign o_gnt       = r_gnt;
    assign o_gnt_idx   = r_gnt_idx;
    assign o_gnt_valid = r_gnt_valid;
    assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Bench for rr_arbiter_16: four instances with different hold limits share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_rr_arbiter_16;

    localparam int NI = 4;
    // Hold limits per instance: 16 (default), 4, 3, unlimited.
    localparam logic [63:0] MH_PACK = {16'd0, 16'd3, 16'd4, 16'd16};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [15:0] req = 16'd0;

    logic [15:0] w_gnt     [NI];
    logic [3:0]  w_idx     [NI];
    logic        w_valid   [NI];
    logic        w_timeout [NI];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            rr_arbiter_16 #(.MAX_HOLD(int'(MH_PACK[gi*16 +: 16]))) u_dut (
                .i_clk      (clk),
                .i_rst      (rst),
                .i_en       (en),
                .i_req      (req),
                .o_gnt      (w_gnt[gi]),
                .o_gnt_idx  (w_idx[gi]),
                .o_gnt_valid(w_valid[gi]),
                .o_timeout  (w_timeout[gi])
            );
        end
    endgenerate

    // Behavioural model state per instance.
    bit m_gr  [NI];
    int m_idx [NI];
    int m_ptr [NI];
    int m_cnt [NI];
    bit m_to  [NI];

    function automatic int mh_of(input int k);
        logic [63:0] p;
        p = MH_PACK;
        return int'(p[k*16 +: 16]);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_gr[k] = 0; m_idx[k] = 0; m_ptr[k] = 0; m_cnt[k] = 0; m_to[k] = 0;
        end
    endtask

    task automatic model_update(input logic e, input logic [15:0] r);
        for (int k = 0; k < NI; k++) begin
            m_to[k] = 0;
            if (!m_gr[k]) begin
                if (e && r != 16'd0) begin
                    for (int j = 0; j < 16; j++) begin
                        if (r[(m_ptr[k] + j) % 16]) begin
                            m_idx[k] = (m_ptr[k] + j) % 16;
                            break;
                        end
                    end
                    m_gr[k]  = 1;
                    m_cnt[k] = 1;
                end
            end else if (!r[m_idx[k]]) begin
                m_gr[k]  = 0;
                m_ptr[k] = (m_idx[k] + 1) % 16;
            end else if (mh_of(k) != 0 && m_cnt[k] == mh_of(k)) begin
                m_gr[k]  = 0;
                m_ptr[k] = (m_idx[k] + 1) % 16;
                m_to[k]  = 1;
            end else if (m_cnt[k] < 65535) begin
                m_cnt[k] = m_cnt[k] + 1;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        for (int k = 0; k < NI; k++) begin
            logic [15:0] eg;
            eg = m_gr[k] ? (16'd1 << m_idx[k]) : 16'd0;
            check_val($sformatf("%s/h%0d/gnt", tag, mh_of(k)), 32'(w_gnt[k]), 32'(eg));
            check_val($sformatf("%s/h%0d/idx", tag, mh_of(k)), 32'(w_idx[k]), m_gr[k] ? 32'(m_idx[k]) : 32'd0);
            check_val($sformatf("%s/h%0d/valid", tag, mh_of(k)), 32'(w_valid[k]), 32'(m_gr[k]));
            check_val($sformatf("%s/h%0d/timeout", tag, mh_of(k)), 32'(w_timeout[k]), 32'(m_to[k]));
        end
    endtask

    string cur_tag = "init";

    task automatic step(input logic e, input logic [15:0] r);
        bit was;
        en  = e;
        req = r;
        was = m_gr[0];
        @(posedge clk);
        model_update(e, r);
        #1;
        compare_all(cur_tag);
        if (m_gr[0] && !was)
            $display("[%0t] %s: grant idx=%0d req=0x%04h", $time, cur_tag, m_idx[0], r);
    endtask

    task automatic apply_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all({cur_tag, "/async_rst"});
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int order_q[$];
        int exp_order[5];
        int cnt16[16];
        int n;
        logic [15:0] r;
        logic prev_v;

        model_reset();
        #12;
        cur_tag = "reset";
        compare_all(cur_tag);
        #2;
        rst = 1'b0;

        // Async reset mid-grant, then first grant uses ptr = 0.
        cur_tag = "rst_mid";
        step(1'b1, 16'h0020);
        step(1'b1, 16'h0020);
        check_val("rst_mid/idx5", 32'(w_idx[0]), 32'd5);
        apply_reset();
        step(1'b1, 16'h8001);
        check_val("rst_mid/first_idx", 32'(w_idx[0]), 32'd0);

        // Round-robin order with 2-cycle grants.
        cur_tag = "rr_seq";
        apply_reset();
        exp_order = '{0, 4, 8, 0, 4};
        prev_v = 1'b0;
        for (int i = 0; i < 40 && order_q.size() < 5; i++) begin
            r = 16'h0111;
            if (m_gr[0] && m_cnt[0] == 2) r[m_idx[0]] = 1'b0;
            step(1'b1, r);
            if (w_valid[0] && !prev_v) order_q.push_back(int'(w_idx[0]));
            prev_v = w_valid[0];
        end
        check_val("rr_seq/count", 32'(order_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < order_q.size(); i++)
            check_val($sformatf("rr_seq/order%0d", i), 32'(order_q[i]), 32'(exp_order[i]));

        // Pointer wrap after idx 15.
        cur_tag = "wrap";
        apply_reset();
        step(1'b1, 16'h8000);
        step(1'b1, 16'h0000);
        step(1'b1, 16'h8002);
        check_val("wrap/idx", 32'(w_idx[0]), 32'd1);

        // Hold limit on the MAX_HOLD=4 instance.
        cur_tag = "hold";
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 16'h0008);
            check_val($sformatf("hold/valid%0d", i), 32'(w_valid[1]), (i == 4) ? 32'd0 : 32'd1);
            check_val($sformatf("hold/timeout%0d", i), 32'(w_timeout[1]), (i == 4) ? 32'd1 : 32'd0);
        end
        check_val("hold/regrant_idx", 32'(w_idx[1]), 32'd3);

        // Enable gating; dropping en keeps the grant until the limit.
        cur_tag = "enable";
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'hFFFF);
            check_val("enable/no_grant", 32'(w_valid[0]), 32'd0);
        end
        step(1'b1, 16'hFFFF);
        check_val("enable/grant_idx", 32'(w_idx[0]), 32'd0);
        for (int i = 0; i < 15; i++) step(1'b0, 16'hFFFF);
        check_val("enable/still_valid", 32'(w_valid[0]), 32'd1);
        step(1'b0, 16'hFFFF);
        check_val("enable/timeout", 32'(w_timeout[0]), 32'd1);
        step(1'b0, 16'hFFFF);
        check_val("enable/no_regrant", 32'(w_valid[0]), 32'd0);

        // Release coinciding with the limit on the MAX_HOLD=3 instance.
        cur_tag = "coincide";
        apply_reset();
        step(1'b1, 16'h0004);
        step(1'b1, 16'h0004);
        step(1'b1, 16'h0004);
        step(1'b1, 16'h0000);
        check_val("coincide/valid", 32'(w_valid[2]), 32'd0);
        check_val("coincide/timeout", 32'(w_timeout[2]), 32'd0);

        // Fairness with all requesting, on the MAX_HOLD=3 instance.
        cur_tag = "fair";
        apply_reset();
        for (int i = 0; i < 16; i++) cnt16[i] = 0;
        n = 0;
        prev_v = 1'b0;
        for (int i = 0; i < 200 && n < 16; i++) begin
            step(1'b1, 16'hFFFF);
            if (w_valid[2] && !prev_v) begin
                cnt16[w_idx[2]]++;
                n++;
            end
            prev_v = w_valid[2];
        end
        check_val("fair/grants", 32'(n), 32'd16);
        for (int i = 0; i < 16; i++)
            check_val($sformatf("fair/idx%0d", i), 32'(cnt16[i]), 32'd1);

        // Randomized traffic.
        cur_tag = "rand";
        apply_reset();
        r = 16'h0000;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 16; b++)
                if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
            if ($urandom_range(0, 299) == 0) apply_reset();
            step($urandom_range(0, 9) != 0, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_16.md
# rr_arbiter_16

Round-robin arbiter that shares one 16-input resource among 16 requesters. It grants exactly one requester at a time, presents the grant both one-hot and as a 4-bit binary index, and holds the grant until the requester releases it or a hold-time limit expires. The arbiter sits in front of the shared datapath; gnt_idx drives its select directly, so no downstream encoder is needed.

## Interface
- MAX_HOLD, default 16: maximum consecutive cycles a single grant may stay asserted (1..65535); 0 means unlimited.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  arbitration enable; when low, no new grant is issued.
- req  input  16  request vector, bit i = requester i; any number of bits may be set.
- gnt  output  16  one-hot grant, registered; all zeros when no grant is active.
- gnt_idx  output  4  binary index of the granted requester; 0 when no grant is active.
- gnt_valid  output  1  high while a grant is active; equals |gnt.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked by MAX_HOLD.

## Operation
- The FSM has two states: IDLE and GRANT.
- Internal state:
  - ptr[3:0]: the highest-priority requester index.
  - hold_cnt, 16 bits wide: counts the cycles of the current grant.
- Reset (asynchronous, takes effect immediately): state IDLE, ptr = 0, hold_cnt = 0, gnt = 0, gnt_idx = 0, gnt_valid = 0, timeout = 0.
- IDLE:
  - If en = 1 and req ≠ 0, select the first set bit of req scanning ptr, ptr+1, … 15, 0, … ptr-1 (mod 16).
  - Register gnt = one-hot of the selected index, gnt_idx = index, gnt_valid = 1, hold_cnt = 1, then go to GRANT.
  - Otherwise stay in IDLE with outputs at zero.
- GRANT, checked in priority order:
  - If req[gnt_idx] = 0: release. Clear gnt, gnt_idx and gnt_valid, set ptr = gnt_idx + 1 (4-bit wrap, 15 → 0), go to IDLE.
  - Else, if MAX_HOLD ≠ 0 and hold_cnt == MAX_HOLD: revoke. Same actions as release, plus timeout = 1 for one cycle.
  - Else: hold the grant and increment hold_cnt (the counter never exceeds MAX_HOLD; it saturates at 0xFFFF when MAX_HOLD = 0).
- en is ignored in GRANT. Dropping en never revokes an active grant.
- Requests from requesters other than the granted one have no effect during GRANT.
- The arbiter always passes through IDLE for at least one cycle between grants, so no two grants are back-to-back. This guarantees a one-cycle bubble on the shared resource.
- A revoked requester is not blacklisted. It becomes lowest priority through the ptr update and may be regranted if it is the only requester.
- gnt, gnt_idx and gnt_valid always change together on the same edge.
- gnt_valid = 0 implies gnt = 0 and gnt_idx = 0.

## Timing
- Grant latency:
  - Request sampled at edge k while in IDLE with en = 1 → gnt is valid after edge k.
  - Minimum latency from req rising to gnt_valid is one cycle.
- Release latency: req[gnt_idx] sampled low at edge m → gnt_valid is low after edge m. The earliest next grant is after edge m+1.
- Grant duration: with req held high, gnt_valid stays high for exactly MAX_HOLD cycles.
  - timeout is high in the cycle immediately after the last grant cycle.
  - The IDLE bubble cycle coincides with the timeout pulse.
- Simultaneous release and limit: if req drops in the same cycle that hold_cnt == MAX_HOLD, the event is treated as a normal release and timeout stays 0.
- Reset mid-grant: outputs clear asynchronously and ptr returns to 0.
  - After rst deasserts, the first edge with req ≠ 0 and en = 1 grants per ptr = 0.
- Fairness: with all 16 requesters continuously requesting, each is granted exactly once in every 16 grants.

## Test plan
- Reset state:
  - Stimulus: rst = 1 mid-grant (gnt_idx = 5).
  - Response: gnt = 0, gnt_idx = 0, gnt_valid = 0 and timeout = 0 before the next clock edge; the first grant after reset with req = 16'h8001 is idx 0.
- Round-robin sequence:
  - Stimulus: req = 16'h0111 constant; each granted requester drops its req for one cycle after 2 grant cycles, then re-raises it.
  - Response: grant order 0, 4, 8, 0, 4; one IDLE cycle between grants.
- Pointer wrap:
  - Stimulus: grant idx 15 completes, then req = 16'h8002.
  - Response: next gnt_idx = 1 (ptr wrapped to 0; bit 1 is found before bit 15).
- Hold limit:
  - Stimulus: MAX_HOLD = 4, req = 16'h0008 held high.
  - Response: gnt_valid high for exactly 4 cycles, then timeout pulses for 1 cycle with gnt = 0, then a regrant of idx 3 on the following cycle.
- Enable gating:
  - Stimulus: en = 0 with req = 16'hFFFF → no grant.
  - Stimulus: en = 1 for one cycle → grant idx 0; en then drops while idx 0 keeps requesting.
  - Response: the grant stays active until the release or the MAX_HOLD limit.
- Release and limit coincide:
  - Stimulus: MAX_HOLD = 3, req[2] drops in the 3rd grant cycle.
  - Response: gnt drops and timeout stays 0.
